// File: rtl/rcu_pll_lock_ctrl.sv
// RCU PLL lock controller: applies PLL configuration, qualifies lock, switches the system clock select.
// Optional automatic lock retry is enabled by defining RCU_LOCK_RETRY_EN.
`ifndef RCU_CLK_CFG_WIDTH
`define RCU_CLK_CFG_WIDTH 8
`endif

module rcu_pll_lock_ctrl #(
   parameter int CFG_WIDTH   = `RCU_CLK_CFG_WIDTH,
   parameter int GUARD_CYC   = 16,
   parameter int STABLE_CYC  = 64,
   parameter int TIMEOUT_CYC = 4096
`ifdef RCU_LOCK_RETRY_EN
   ,
   parameter int RETRY_NUM   = 3
`endif
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 cfg_upd_i,
   input  logic [CFG_WIDTH-1:0] cfg_i,
   input  logic                 pll_lock_i,
   input  logic                 err_clr_i,
   output logic [CFG_WIDTH-1:0] clk_cfg_o,
   output logic                 clk_sel_o,
   output logic                 locked_o,
   output logic                 busy_o,
   output logic                 lock_err_o,
   output logic [1:0]           err_code_o
);

   localparam int GW = $clog2(GUARD_CYC) + 1;
   localparam int SW = $clog2(STABLE_CYC) + 1;
   localparam int TW = $clog2(TIMEOUT_CYC) + 1;

   localparam logic [GW-1:0] GUARD_ZERO = GW'(1'b0);
   localparam logic [GW-1:0] GUARD_ONE  = GW'(1'b1);
   localparam logic [GW-1:0] GUARD_MAX  = {GW{1'b1}};
   localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYC - 1);
   localparam logic [SW-1:0] STB_ZERO   = SW'(1'b0);
   localparam logic [SW-1:0] STB_ONE    = SW'(1'b1);
   localparam logic [SW-1:0] STB_MAX    = {SW{1'b1}};
   localparam logic [SW-1:0] STB_LAST   = SW'(STABLE_CYC - 1);
   localparam logic [TW-1:0] TMO_ZERO   = TW'(1'b0);
   localparam logic [TW-1:0] TMO_ONE    = TW'(1'b1);
   localparam logic [TW-1:0] TMO_MAX    = {TW{1'b1}};
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_TIMEOUT = 2'd1;
   localparam logic [1:0] ERR_LOST    = 2'd2;

   typedef enum logic [2:0] {
      ST_REF   = 3'd0,
      ST_GUARD = 3'd1,
      ST_WAIT  = 3'd2,
      ST_RUN   = 3'd3,
      ST_FAIL  = 3'd4
   } state_t;

   state_t               state_r, state_nxt_s;
   logic                 lock_meta_r, lock_sync_r;
   logic [CFG_WIDTH-1:0] shadow_r, shadow_nxt_s;
   logic [CFG_WIDTH-1:0] cfg_r, cfg_nxt_s;
   logic [GW-1:0]        guard_cnt_r, guard_cnt_nxt_s, guard_inc_s;
   logic [SW-1:0]        stb_cnt_r, stb_cnt_nxt_s, stb_inc_s;
   logic [TW-1:0]        tmo_cnt_r, tmo_cnt_nxt_s, tmo_inc_s;
   logic                 sel_r, sel_nxt_s;
   logic                 locked_r, locked_nxt_s;
   logic                 busy_r, busy_nxt_s;
   logic                 err_r, err_nxt_s;
   logic [1:0]           code_r, code_nxt_s;
   logic                 fail_s;
   logic [1:0]           fail_code_s;

   // Counters saturate rather than wrap.
   assign guard_inc_s = (guard_cnt_r == GUARD_MAX) ? guard_cnt_r : guard_cnt_r + GUARD_ONE;
   assign stb_inc_s   = (stb_cnt_r == STB_MAX) ? stb_cnt_r : stb_cnt_r + STB_ONE;
   assign tmo_inc_s   = (tmo_cnt_r == TMO_MAX) ? tmo_cnt_r : tmo_cnt_r + TMO_ONE;

`ifdef RCU_LOCK_RETRY_EN
   localparam int RW = $clog2(RETRY_NUM) + 1;
   localparam logic [RW-1:0] RETRY_ZERO = RW'(1'b0);
   localparam logic [RW-1:0] RETRY_ONE  = RW'(1'b1);
   localparam logic [RW-1:0] RETRY_LIM  = RW'(RETRY_NUM);

   logic [RW-1:0] retry_cnt_r, retry_cnt_nxt_s;
   logic          retry_pend_r, retry_pend_nxt_s;

   // Retry bookkeeping: a failure arms one re-entry into GUARD while retries remain.
   always_comb begin
      retry_cnt_nxt_s  = retry_cnt_r;
      retry_pend_nxt_s = 1'b0;
      if (cfg_upd_i) begin
         retry_cnt_nxt_s = RETRY_ZERO;
      end else if (fail_s) begin
         if (retry_cnt_r < RETRY_LIM) begin
            retry_cnt_nxt_s  = retry_cnt_r + RETRY_ONE;
            retry_pend_nxt_s = 1'b1;
         end else begin
            retry_pend_nxt_s = 1'b0;
         end
      end else if (state_nxt_s == ST_RUN) begin
         retry_cnt_nxt_s = RETRY_ZERO;
      end else begin
         retry_cnt_nxt_s = retry_cnt_r;
      end
   end

   // Retry count and pending flag registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         retry_cnt_r  <= RETRY_ZERO;
         retry_pend_r <= 1'b0;
      end else begin
         retry_cnt_r  <= retry_cnt_nxt_s;
         retry_pend_r <= retry_pend_nxt_s;
      end
   end
`endif

   // Two-flop synchronizer for the asynchronous PLL lock.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         lock_meta_r <= 1'b0;
         lock_sync_r <= 1'b0;
      end else begin
         lock_meta_r <= pll_lock_i;
         lock_sync_r <= lock_meta_r;
      end
   end

   // Next-state, counter and output decode.
   always_comb begin
      state_nxt_s     = state_r;
      shadow_nxt_s    = shadow_r;
      cfg_nxt_s       = cfg_r;
      guard_cnt_nxt_s = guard_cnt_r;
      stb_cnt_nxt_s   = stb_cnt_r;
      tmo_cnt_nxt_s   = tmo_cnt_r;
      fail_s          = 1'b0;
      fail_code_s     = ERR_NONE;
      err_nxt_s       = err_r;
      code_nxt_s      = code_r;
      if (cfg_upd_i) begin
         shadow_nxt_s    = cfg_i;
         guard_cnt_nxt_s = GUARD_ZERO;
         state_nxt_s     = ST_GUARD;
      end else begin
         case (state_r)
            ST_REF: state_nxt_s = ST_REF;
            ST_GUARD: begin
               if (guard_cnt_r == GUARD_LAST) begin
                  cfg_nxt_s     = shadow_r;
                  tmo_cnt_nxt_s = TMO_ZERO;
                  stb_cnt_nxt_s = STB_ZERO;
                  state_nxt_s   = ST_WAIT;
               end else begin
                  guard_cnt_nxt_s = guard_inc_s;
               end
            end
            ST_WAIT: begin
               tmo_cnt_nxt_s = tmo_inc_s;
               if (lock_sync_r) begin
                  stb_cnt_nxt_s = stb_inc_s;
               end else begin
                  stb_cnt_nxt_s = STB_ZERO;
               end
               // Qualification takes priority over a coincident timeout.
               if (lock_sync_r && (stb_cnt_r == STB_LAST)) begin
                  state_nxt_s = ST_RUN;
               end else if (tmo_cnt_r == TMO_LAST) begin
                  fail_s      = 1'b1;
                  fail_code_s = ERR_TIMEOUT;
                  state_nxt_s = ST_FAIL;
               end else begin
                  state_nxt_s = ST_WAIT;
               end
            end
            ST_RUN: begin
               if (!lock_sync_r) begin
                  fail_s      = 1'b1;
                  fail_code_s = ERR_LOST;
                  state_nxt_s = ST_FAIL;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end
            ST_FAIL: begin
`ifdef RCU_LOCK_RETRY_EN
               if (retry_pend_r) begin
                  guard_cnt_nxt_s = GUARD_ZERO;
                  state_nxt_s     = ST_GUARD;
               end else begin
                  state_nxt_s = ST_FAIL;
               end
`else
               state_nxt_s = ST_FAIL;
`endif
            end
            default: state_nxt_s = ST_REF;
         endcase
      end
      sel_nxt_s    = (state_nxt_s == ST_RUN);
      locked_nxt_s = (state_nxt_s == ST_RUN);
      busy_nxt_s   = (state_nxt_s == ST_GUARD) || (state_nxt_s == ST_WAIT);
      if (fail_s) begin
         err_nxt_s  = 1'b1;
         code_nxt_s = fail_code_s;
      end else if (err_clr_i) begin
         err_nxt_s  = 1'b0;
         code_nxt_s = ERR_NONE;
      end else begin
         err_nxt_s  = err_r;
         code_nxt_s = code_r;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r <= ST_REF;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Datapath, counters and registered outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         shadow_r    <= {CFG_WIDTH{1'b0}};
         cfg_r       <= {CFG_WIDTH{1'b0}};
         guard_cnt_r <= GUARD_ZERO;
         stb_cnt_r   <= STB_ZERO;
         tmo_cnt_r   <= TMO_ZERO;
         sel_r       <= 1'b0;
         locked_r    <= 1'b0;
         busy_r      <= 1'b0;
         err_r       <= 1'b0;
         code_r      <= ERR_NONE;
      end else begin
         shadow_r    <= shadow_nxt_s;
         cfg_r       <= cfg_nxt_s;
         guard_cnt_r <= guard_cnt_nxt_s;
         stb_cnt_r   <= stb_cnt_nxt_s;
         tmo_cnt_r   <= tmo_cnt_nxt_s;
         sel_r       <= sel_nxt_s;
         locked_r    <= locked_nxt_s;
         busy_r      <= busy_nxt_s;
         err_r       <= err_nxt_s;
         code_r      <= code_nxt_s;
      end
   end

   assign clk_cfg_o  = cfg_r;
   assign clk_sel_o  = sel_r;
   assign locked_o   = locked_r;
   assign busy_o     = busy_r;
   assign lock_err_o = err_r;
   assign err_code_o = code_r;

endmodule
